// File: rtl/aib_arb_pkg.sv
// Shared types and widths for the AIB Tx arbiter and its round-robin picker.
package aib_arb_pkg;

  localparam int AIB_ARB_ID_W   = 4;
  localparam int AIB_ARB_PLD_W  = 68;
  localparam int AIB_ARB_BEAT_W = AIB_ARB_ID_W + AIB_ARB_PLD_W;

  // ARB: free round-robin choice; LOCK: only the packet owner may send.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // One channel beat: source ID in the top nibble, payload below it.
  typedef struct packed {
    logic [AIB_ARB_ID_W-1:0]  id;
    logic [AIB_ARB_PLD_W-1:0] payload;
  } arb_beat_t;

endpackage

// File: rtl/aib_rr_pick.sv
// Combinational round-robin priority picker: first eligible requester
// searching from i_ptr upward, wrapping modulo N. Returns a one-hot grant
// and the encoded winner (zero when nothing is eligible).
module aib_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_elig,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_winner
);

  logic [PTR_W:0] w_idx;
  logic           w_found;

  // Walk the rotated priority order and latch onto the first eligible slot.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_idx >= (PTR_W + 1)'(N)) w_idx = w_idx - (PTR_W + 1)'(N);
      if (!w_found && i_elig[w_idx[PTR_W-1:0]]) begin
        w_found                     = 1'b1;
        o_grant[w_idx[PTR_W-1:0]]   = 1'b1;
        o_winner                    = w_idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/aib_tx_arbiter.sv
// AIB channel Tx arbiter: NUM_REQ requesters share one 72-bit valid/ready
// channel. Round-robin between packets, no interleaving inside a packet.
// Optional per-requester credit gating is compiled in with AIB_ARB_CREDIT_EN.
//
// Handshake: a beat moves when valid & ready are both high on a clock edge;
// valid never waits for ready, and a raised valid holds its data until taken.
module aib_tx_arbiter
  import aib_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8
) (
  input  logic                                    i_aib_clk,
  input  logic                                    i_rst_n,
  input  logic [NUM_REQ-1:0]                      i_req_valid,
  output logic [NUM_REQ-1:0]                      o_req_ready,
  input  logic [NUM_REQ-1:0]                      i_req_last,
  input  logic [NUM_REQ-1:0][AIB_ARB_PLD_W-1:0]   i_req_data,
  output logic                                    o_tx_valid,
  input  logic                                    i_tx_ready,
  output logic [AIB_ARB_BEAT_W-1:0]               o_tx_data,
  output logic                                    o_busy
`ifdef AIB_ARB_CREDIT_EN
  ,
  input  logic                                    i_crd_ret_valid,
  input  logic [AIB_ARB_ID_W-1:0]                 i_crd_ret_id,
  output logic                                    o_crd_err
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_tx_valid;
  arb_beat_t          r_tx_data;

  logic               w_load_en;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [PTR_W-1:0]   w_pick_win;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_win;
  logic               w_accept;
  logic               w_acc_last;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // The output register may load when it is empty or being drained this cycle.
  assign w_load_en  = !r_tx_valid || i_tx_ready;
  assign o_req_ready = (i_rst_n && w_load_en) ? w_grant : '0;
  assign w_accept   = |o_req_ready;
  assign w_acc_last = i_req_last[w_win];
  assign w_ptr_nxt  = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);

`ifdef AIB_ARB_CREDIT_EN
  localparam int CRD_W = $clog2(CREDITS + 1);

  logic [CRD_W-1:0]   r_credit [NUM_REQ];
  logic               r_crd_err;
  logic [NUM_REQ-1:0] w_ret_hit;
  logic [NUM_REQ-1:0] w_ret_ovf;
  logic               w_ret_bad_id;

  assign w_ret_bad_id = i_crd_ret_valid && (int'(i_crd_ret_id) >= NUM_REQ);
  assign o_crd_err    = r_crd_err;

  // A requester competes only while it has a valid beat and credit left.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_elig[i] = i_req_valid[i] && (r_credit[i] != '0);
  end

  // Classify a credit return: a return into a full counter (with no
  // simultaneous spend to absorb it) is an overflow and is discarded.
  always_comb begin
    w_ret_hit = '0;
    w_ret_ovf = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_crd_ret_valid && (i_crd_ret_id == AIB_ARB_ID_W'(i))) begin
        if ((r_credit[i] == CRD_W'(CREDITS)) && !o_req_ready[i]) w_ret_ovf[i] = 1'b1;
        else                                                      w_ret_hit[i] = 1'b1;
      end
    end
  end

  // Credit counters: spend on accept, refill on return, both cancel out.
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= CRD_W'(CREDITS);
      r_crd_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (o_req_ready[i] && !w_ret_hit[i])      r_credit[i] <= r_credit[i] - CRD_W'(1);
        else if (!o_req_ready[i] && w_ret_hit[i]) r_credit[i] <= r_credit[i] + CRD_W'(1);
      end
      if (w_ret_bad_id || (|w_ret_ovf)) r_crd_err <= 1'b1;
    end
  end
`else
  assign w_elig = i_req_valid;
`endif

  aib_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_grant  (w_pick_grant),
    .o_winner (w_pick_win)
  );

  // FSM state register.
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ARB;
    else          r_state <= w_next_state;
  end

  // FSM next state: lock on a non-last beat, unlock on the owner's last beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB:     if (w_accept && !w_acc_last) w_next_state = LOCK;
      LOCK:    if (w_accept && w_acc_last)  w_next_state = ARB;
      default: w_next_state = ARB;
    endcase
  end

  // FSM outputs: picker result in ARB, owner-only grant in LOCK.
  always_comb begin
    w_grant = '0;
    w_win   = r_owner;
    case (r_state)
      ARB: begin
        w_grant = w_pick_grant;
        w_win   = w_pick_win;
      end
      LOCK:    w_grant[r_owner] = w_elig[r_owner];
      default: w_grant = '0;
    endcase
  end

  // Pointer advances only on packet completion; owner is captured on lock.
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_accept) begin
      if (w_acc_last) r_ptr   <= w_ptr_nxt;
      else            r_owner <= w_win;
    end
  end

  // Single-stage output register towards the channel.
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_load_en) begin
      r_tx_valid <= w_accept;
      if (w_accept) begin
        r_tx_data.id      <= AIB_ARB_ID_W'(w_win);
        r_tx_data.payload <= i_req_data[w_win];
      end
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state == LOCK) || r_tx_valid;

endmodule

// File: tb/tb_aib_tx_arbiter.sv
// Bench for aib_tx_arbiter: directed scenarios with literal expectations,
// then randomized packet traffic checked every cycle against a queue model.
`timescale 1ns/1ps
module tb_aib_tx_arbiter;
  import aib_arb_pkg::*;

  localparam int N       = 4;
  localparam int CREDITS = 2;
  localparam int W       = AIB_ARB_BEAT_W;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic [N-1:0]                    req_valid = '0;
  logic [N-1:0]                    req_ready;
  logic [N-1:0]                    req_last = '0;
  logic [N-1:0][AIB_ARB_PLD_W-1:0] req_data = '0;
  logic                            tx_valid;
  logic                            tx_ready = 1'b1;
  logic [W-1:0]                    tx_data;
  logic                            busy;
`ifdef AIB_ARB_CREDIT_EN
  logic                            crd_ret_valid = 1'b0;
  logic [3:0]                      crd_ret_id = '0;
  logic                            crd_err;
`endif

  aib_tx_arbiter #(
    .NUM_REQ (N),
    .CREDITS (CREDITS)
  ) dut (
    .i_aib_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_tx_data   (tx_data),
    .o_busy      (busy)
`ifdef AIB_ARB_CREDIT_EN
    ,
    .i_crd_ret_valid (crd_ret_valid),
    .i_crd_ret_id    (crd_ret_id),
    .o_crd_err       (crd_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AIB_ARB_PLD_W-1:0] rand68();
    return {$urandom, $urandom, 4'($urandom)};
  endfunction

  // ---------------- behavioural model ----------------
  // exp_q holds beats accepted but not yet taken by the channel (at most one
  // can be in flight). m_owner is -1 when no packet is open.
  logic [W-1:0] exp_q[$];
  int           m_owner = -1;
  int           m_ptr   = 0;
  logic [N-1:0] m_acc   = '0;
`ifdef AIB_ARB_CREDIT_EN
  int           m_cred[N];
  logic         m_err = 1'b0;
`endif

  task automatic model_reset();
    exp_q.delete();
    m_owner = -1;
    m_ptr   = 0;
    m_acc   = '0;
`ifdef AIB_ARB_CREDIT_EN
    for (int i = 0; i < N; i++) m_cred[i] = CREDITS;
    m_err = 1'b0;
`endif
  endtask

  // Compare process: checks every cycle on the falling edge, then advances the model.
  always @(negedge clk) begin
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    bit           load;
    bit           found;
    int           j;
    if (!rst_n) begin
      model_reset();
      check("rst_ready", W'(req_ready), '0);
      check("rst_tx_valid", W'(tx_valid), '0);
      check("rst_tx_data", tx_data, '0);
      check("rst_busy", W'(busy), '0);
    end else begin
      for (int i = 0; i < N; i++) begin
        elig[i] = req_valid[i];
`ifdef AIB_ARB_CREDIT_EN
        if (m_cred[i] == 0) elig[i] = 1'b0;
`endif
      end
      load    = (exp_q.size() == 0) || tx_ready;
      exp_rdy = '0;
      found   = 1'b0;
      if (load) begin
        if (m_owner >= 0) begin
          if (elig[m_owner]) exp_rdy[m_owner] = 1'b1;
        end else begin
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && elig[j]) begin
              found      = 1'b1;
              exp_rdy[j] = 1'b1;
            end
          end
        end
      end
      check("req_ready", W'(req_ready), W'(exp_rdy));
      check("tx_valid", W'(tx_valid), W'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
      check("busy", W'(busy), W'((m_owner >= 0) || (exp_q.size() != 0)));
`ifdef AIB_ARB_CREDIT_EN
      check("crd_err", W'(crd_err), W'(m_err));
`endif
      if (exp_q.size() != 0 && tx_ready) void'(exp_q.pop_front());
`ifdef AIB_ARB_CREDIT_EN
      if (crd_ret_valid) begin
        if (int'(crd_ret_id) >= N) m_err = 1'b1;
        else if (m_cred[crd_ret_id] == CREDITS && !exp_rdy[crd_ret_id]) m_err = 1'b1;
        else m_cred[crd_ret_id]++;
      end
`endif
      for (int i = 0; i < N; i++) begin
        if (exp_rdy[i]) begin
          exp_q.push_back({4'(i), req_data[i]});
`ifdef AIB_ARB_CREDIT_EN
          m_cred[i]--;
`endif
          if (req_last[i]) begin
            m_owner = -1;
            m_ptr   = (i + 1) % N;
          end else begin
            m_owner = i;
          end
        end
      end
      m_acc = exp_rdy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    req_valid = '0;
    tx_ready  = 1'b1;
`ifdef AIB_ARB_CREDIT_EN
    crd_ret_valid = 1'b0;
`endif
    repeat (n) step();
  endtask

  // Return outstanding credits one per cycle until every counter is full.
  task automatic refill();
`ifdef AIB_ARB_CREDIT_EN
    for (int t = 0; t < 4 * N * CREDITS; t++) begin
      int id;
      id = -1;
      for (int i = 0; i < N; i++) if (id < 0 && m_cred[i] < CREDITS) id = i;
      if (id < 0) break;
      crd_ret_valid = 1'b1;
      crd_ret_id    = 4'(id);
      step();
    end
    crd_ret_valid = 1'b0;
`endif
  endtask

  int           exp_ids[5] = '{0, 1, 2, 3, 0};
  int           pkt_left[N];
  int           open;
  logic [W-1:0] held;

  initial begin
    // Reset: valid asserted must still see no ready.
    req_valid = '1;
    repeat (3) step();
    check("t1_rst_ready_gated", W'(req_ready), '0);
    check("t1_rst_tx_valid", W'(tx_valid), '0);
    req_valid = '0;
    rst_n = 1'b1;

    // All valid, all single-beat: IDs 0,1,2,3,0 back to back.
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) req_data[i] = rand68();
    tx_ready = 1'b1;
    #1;
    check("t2_no_valid_before_accept", W'(tx_valid), '0);
    check("t2_first_grant", W'(req_ready), W'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_valid", W'(tx_valid), W'(1'b1));
      check("t2_id", W'(tx_data[71:68]), W'(exp_ids[k]));
    end
    req_valid = '0;
    idle(2);
    refill();

    // Req1 three-beat packet with req0/req2 also requesting.
    req_valid = 4'b0111;
    req_last  = 4'b0101;
`ifdef AIB_ARB_CREDIT_EN
    crd_ret_valid = 1'b1;
    crd_ret_id    = 4'd1;
`endif
    #1;
    check("t3_grant_req1", W'(req_ready), W'(4'b0010));
    step();
    check("t3_beat1_id", W'(tx_data[71:68]), W'(4'd1));
    req_data[1] = rand68();
    #1;
    check("t3_locked_ready", W'(req_ready), W'(4'b0010));
    step();
    check("t3_beat2_id", W'(tx_data[71:68]), W'(4'd1));
    req_data[1] = rand68();
    req_last[1] = 1'b1;
    step();
    check("t3_beat3_id", W'(tx_data[71:68]), W'(4'd1));
    req_valid[1] = 1'b0;
`ifdef AIB_ARB_CREDIT_EN
    crd_ret_valid = 1'b0;
`endif
    #1;
    check("t3_next_grant_req2", W'(req_ready), W'(4'b0100));
    step();
    check("t3_after_id", W'(tx_data[71:68]), W'(4'd2));
    req_valid = '0;
    idle(2);
    refill();

    // Channel back-pressure for five cycles.
    tx_ready  = 1'b0;
    req_valid = '1;
    req_last  = '1;
    step();
    check("t4_valid", W'(tx_valid), W'(1'b1));
    check("t4_held_id", W'(tx_data[71:68]), W'(4'd3));
    held = tx_data;
    for (int k = 0; k < 5; k++) begin
      check("t4_data_stable", tx_data, held);
      check("t4_no_ready", W'(req_ready), '0);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("t4_release_id", W'(tx_data[71:68]), W'(4'd0));
    step();
    req_valid = '0;
    idle(3);
    refill();

    // Randomized packet traffic, then drain every open packet.
    for (int i = 0; i < N; i++) pkt_left[i] = 0;
    open = 0;
    for (int c = 0; c < 2600; c++) begin
      open = 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_acc[i]) begin
          pkt_left[i]--;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && (pkt_left[i] > 0 || c < 2000) && $urandom_range(0, 1) == 1) begin
          if (pkt_left[i] == 0) pkt_left[i] = $urandom_range(1, 4);
          req_valid[i] = 1'b1;
          req_last[i]  = (pkt_left[i] == 1);
          req_data[i]  = rand68();
        end
        open += pkt_left[i];
      end
      if (c >= 2000 && open == 0) break;
      tx_ready = (c >= 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
`ifdef AIB_ARB_CREDIT_EN
      crd_ret_valid = 1'b0;
      if (c >= 2000 || $urandom_range(0, 2) == 0) begin
        int s;
        s = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
          if (!crd_ret_valid && m_cred[(s + k) % N] < CREDITS) begin
            crd_ret_valid = 1'b1;
            crd_ret_id    = 4'((s + k) % N);
          end
        end
      end
`endif
      step();
    end
    check("rand_drained", W'(open), '0);
    idle(3);
    refill();

    // Reset in the middle of a locked packet.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    step();
    req_data[2] = rand68();
    step();
    check("t7_busy_locked", W'(busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t7_rst_tx_valid", W'(tx_valid), '0);
    check("t7_rst_ready", W'(req_ready), '0);
    req_valid = '0;
    step();
    step();
    rst_n     = 1'b1;
    req_valid = '1;
    req_last  = '1;
    #1;
    check("t7_ptr0_grant", W'(req_ready), W'(4'b0001));
    step();
    check("t7_first_id", W'(tx_data[71:68]), W'(4'd0));
    step();
    check("t7_second_id", W'(tx_data[71:68]), W'(4'd1));
    req_valid = '0;
    idle(2);
    refill();

`ifdef AIB_ARB_CREDIT_EN
    // Req3 exhausts its two credits, then returns unblock it.
    req_valid = 4'b1000;
    req_last  = '1;
    step();
    step();
    check("t5_req3_blocked", W'(req_ready[3]), '0);
    crd_ret_valid = 1'b1;
    crd_ret_id    = 4'd3;
    step();
    check("t5_req3_regranted", W'(req_ready[3]), W'(1'b1));
    step();
    crd_ret_valid = 1'b0;
    #1;
    check("t5_accept_return_same", W'(req_ready[3]), W'(1'b1));
    step();
    check("t5_req3_blocked_again", W'(req_ready[3]), '0);
    req_valid = '0;
    idle(2);
    refill();

    // Overflow return is sticky until reset; bad ID also flags.
    check("t6_err_clear", W'(crd_err), '0);
    crd_ret_valid = 1'b1;
    crd_ret_id    = 4'd0;
    step();
    crd_ret_valid = 1'b0;
    #1;
    check("t6_err_set", W'(crd_err), W'(1'b1));
    idle(5);
    check("t6_err_sticky", W'(crd_err), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t6_err_rst", W'(crd_err), '0);
    step();
    rst_n         = 1'b1;
    crd_ret_valid = 1'b1;
    crd_ret_id    = 4'd5;
    step();
    crd_ret_valid = 1'b0;
    #1;
    check("t6_bad_id_err", W'(crd_err), W'(1'b1));
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aib_tx_arbiter.md
Name: aib_tx_arbiter

Overview:
- Shares one AIB channel Tx datapath (72-bit valid/ready, running on i_aib_clk) between NUM_REQ independent requesters.
- Round-robin arbitration with packet locking: a multi-beat packet is never interleaved with another requester's beats.
- Each beat carries a 4-bit source ID and a 68-bit payload; the far-side Rx demux routes on the ID.
- Sits between the client-side traffic sources and the channel's i_tx_valid/o_tx_ready/i_tx_data interface.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- CREDITS, 8, initial/maximum per-requester credit count; only used with AIB_ARB_CREDIT_EN.

Ports:
- i_aib_clk  input  1  channel clock; the only clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester beat valid.
- o_req_ready  output  NUM_REQ  per-requester beat accept.
- i_req_last  input  NUM_REQ  beat is the last beat of a packet.
- i_req_data  input  NUM_REQ x 68  per-requester payload.
- o_tx_valid  output  1  to channel i_tx_valid.
- i_tx_ready  input  1  from channel o_tx_ready.
- o_tx_data  output  72  to channel i_tx_data; [71:68]=source ID, [67:0]=payload.
- o_busy  output  1  high while in LOCK state or while o_tx_valid is high.
- i_crd_ret_valid  input  1  (AIB_ARB_CREDIT_EN only) one credit is returned.
- i_crd_ret_id  input  4  (AIB_ARB_CREDIT_EN only) requester receiving the returned credit.
- o_crd_err  output  1  (AIB_ARB_CREDIT_EN only) sticky credit-overflow flag.

Behaviour:
- Reset (async assert, sync release):
  - o_tx_valid=0, o_tx_data=0.
  - RR pointer=0; state=ARB.
  - Credits=CREDITS for every requester; o_crd_err=0.
  - o_req_ready=0 for every requester while i_rst_n is low.
- Output stage is a single register:
  - load_en = !o_tx_valid | i_tx_ready.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data is held stable.
  - Full throughput: one beat per cycle when i_tx_ready stays high.
- Eligibility: requester i is eligible when i_req_valid[i]=1, plus credit[i]>0 when AIB_ARB_CREDIT_EN is defined.
- o_req_ready[i] = load_en & grant[i]. It is combinational from i_tx_ready and i_req_valid, with no combinational path from i_req_data.
- Beat acceptance and latency:
  - A beat is accepted when i_req_valid[i] & o_req_ready[i].
  - On the next edge: o_tx_data <= {i[3:0], i_req_data[i]} and o_tx_valid <= 1.
  - Latency from acceptance to o_tx_valid is 1 cycle.
- If load_en=1 and no requester is granted, o_tx_valid <= 0.
- State ARB:
  - grant = first eligible requester searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Accepted beat with i_req_last=1: ptr <= winner+1 (mod NUM_REQ); stay in ARB.
  - Accepted beat with i_req_last=0: owner <= winner; go to LOCK.
- State LOCK:
  - Only owner may be granted; all other requesters see o_req_ready=0 even if owner is idle (i_req_valid low).
  - Accepted beat from owner with i_req_last=1: ptr <= owner+1; go to ARB.
- Pointer behaviour: the pointer moves only on packet completion, never on idle cycles.
- Credit counters (AIB_ARB_CREDIT_EN only):
  - Accept-only: credit[i] decrements by 1.
  - Return-only for i: credit[i] increments by 1.
  - Accept and return for the same i in the same cycle: credit[i] unchanged.
  - Return when credit[i]==CREDITS: ignored, o_crd_err <= 1 (sticky until reset).
  - i_crd_ret_id >= NUM_REQ: ignored, o_crd_err <= 1.
- Credit exhaustion in LOCK: if the owner reaches 0 credits mid-packet, the arbiter stays in LOCK and stalls until a credit returns. Credit exhaustion does not cause a deadlock break.
- Reset asserted mid-packet: state returns to ARB and any partial packet is dropped. Upstream must also reset.

Optional Feature:
- Macro: AIB_ARB_CREDIT_EN.
- Defined: credit ports, per-requester counters of width $clog2(CREDITS+1), credit gating of eligibility, and o_crd_err are all present.
- Undefined: credit ports and o_crd_err are absent, and eligibility = i_req_valid only.

Decomposition:
- Package aib_arb_pkg:
  - AIB_ARB_ID_W=4, AIB_ARB_PLD_W=68.
  - Typedef arb_state_e {ARB, LOCK}.
  - Packed struct arb_beat_t {id, payload}, which is 72 bits.
- One sub-module, aib_rr_pick: a combinational round-robin priority picker taking eligible vector and pointer, producing a one-hot grant and an encoded winner. It is reused by the Rx-side credit scheduler.

Test Plan:
- NUM_REQ=4, all valid, all last=1, tx_ready=1 -> o_tx_data IDs 0,1,2,3,0 on consecutive cycles; first o_tx_valid appears 1 cycle after the first accept.
- Req1 sends a 3-beat packet (last on beat 3) while req0/req2 are valid -> three ID=1 beats back to back, then grant goes to req2.
- Hold tx_ready=0 for 5 cycles with o_tx_valid=1 -> o_tx_data stable, all o_req_ready=0; release -> no beat lost or duplicated.
- CREDIT_EN, CREDITS=2: req3 sends 2 single beats -> req3 is blocked; i_crd_ret_valid with id=3 -> req3 is granted next cycle; accept and return for req3 in the same cycle -> count unchanged.
- CREDIT_EN: return for req0 at full credit -> o_crd_err=1 and stays high until i_rst_n=0.
- Assert i_rst_n=0 mid-LOCK -> o_tx_valid=0 immediately, state=ARB, ptr=0 after release.
